// File: rtl/svi_ioctl_loader.sv
// svi_ioctl_loader: moves the mist_io ioctl byte stream into main RAM/SDRAM.
//
// Bytes that pass the accept check go into a small FIFO. Each entry holds
// {slot address, data}, where the slot is taken from ioctl_index. The FIFO head
// is written to memory under a we/rdy handshake. mist_io is held off through a
// registered ioctl_wait, which leaves one strobe of slack before the FIFO is full.
//
// Optional build macro: SVI_LOADER_CHECKSUM_EN. When it is defined, checksum is
// the mod-256 sum of the accepted bytes. When it is not defined, checksum is tied to 0.
//
// Ports:
//   clk_sys, reset           system clock, asynchronous active-high reset
//   ioctl_download/index/wr/addr/dout   mist_io download stream
//   ioctl_wait               back-pressure to mist_io
//   mem_addr/mem_din/mem_we  memory write request, held until mem_rdy
//   mem_rdy                  memory accepts when mem_we & mem_rdy
//   busy, done               FSM not idle / one-cycle completion pulse
//   err                      sticky dropped-byte flag
//   byte_count, checksum     per-download statistics
module svi_ioctl_loader #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned SLOT_W    = 1,
  parameter int unsigned SLOT_LOG2 = 16,
  parameter int unsigned FIFO_LOG2 = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic              mem_rdy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [24:0]       byte_count,
  output logic [7:0]        checksum
);

  localparam int unsigned Depth = 2 ** FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FullCnt = (FIFO_LOG2 + 1)'(Depth);
  localparam logic [FIFO_LOG2:0] WaitCnt = (FIFO_LOG2 + 1)'(Depth - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e state_q, state_d;
  logic   dl_q;

  logic [ADDR_W-1:0]    fifo_addr_q [Depth];
  logic [7:0]           fifo_data_q [Depth];
  logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_LOG2:0]   count_q, count_d;

  logic        wait_q;
  logic        err_q, err_d;
  logic [24:0] byte_count_q, byte_count_d;

  logic              wr_req, in_range, full, push, pop, drop;
  logic              dl_rise, dl_fall, clr;
  logic [ADDR_W-1:0] map_addr;

  // The upper index bits do not select anything.
  logic unused_idx;
  assign unused_idx = ^ioctl_index[7:SLOT_W];

  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign map_addr = {ioctl_index[SLOT_W-1:0], ioctl_addr[SLOT_LOG2-1:0]};
  assign in_range = (ioctl_addr >> SLOT_LOG2) == '0;
  assign full     = count_q == FullCnt;
  assign wr_req   = ioctl_download & ioctl_wr;
  assign push     = wr_req & ~full & in_range;
  assign drop     = wr_req & ~push;
  assign mem_we   = count_q != '0;
  assign pop      = mem_we & mem_rdy;

  // The head is gated so that an idle or reset port shows zeros, not stale storage.
  assign mem_addr = mem_we ? fifo_addr_q[rd_ptr_q] : '0;
  assign mem_din  = mem_we ? fifo_data_q[rd_ptr_q] : '0;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    unique case (state_q)
      StIdle: if (dl_rise) begin
        state_d = StLoad;
        clr     = 1'b1;
      end
      StLoad: if (dl_fall) state_d = StDrain;
      // A restart while draining keeps the statistics and queues behind old bytes.
      StDrain: begin
        if (dl_rise)              state_d = StLoad;
        else if (count_q == '0)   state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        if (dl_rise) begin
          state_d = StLoad;
          clr     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_d = clr ? 1'b0 : err_q;
    if (drop) err_d = 1'b1;
    byte_count_d = (clr ? 25'd0 : byte_count_q) + 25'(push);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      dl_q         <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wait_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      dl_q         <= ioctl_download;
      count_q      <= count_d;
      wait_q       <= count_d >= WaitCnt;
      err_q        <= err_d;
      byte_count_q <= byte_count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset. Occupancy is tracked by count_q alone.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= map_addr;
      fifo_data_q[wr_ptr_q] <= ioctl_dout;
    end
  end

`ifdef SVI_LOADER_CHECKSUM_EN
  logic [7:0] checksum_q;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= (clr ? 8'd0 : checksum_q) + (push ? ioctl_dout : 8'd0);
  end
  assign checksum = checksum_q;
`else
  assign checksum = 8'd0;
`endif

  assign ioctl_wait = wait_q;
  assign err        = err_q;
  assign byte_count = byte_count_q;
  assign busy       = state_q != StIdle;
  assign done       = state_q == StDone;

endmodule

// File: tb/tb_svi_ioctl_loader.sv
// Directed self-checking bench for svi_ioctl_loader with default parameters
// (18-bit address, 2 slots of 64 KiB, 4-entry FIFO).
module tb_svi_ioctl_loader;

`ifdef SVI_LOADER_CHECKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr, ioctl_wait, mem_we, mem_rdy;
  logic [7:0]  ioctl_index, ioctl_dout, mem_din, checksum;
  logic [24:0] ioctl_addr, byte_count;
  logic [17:0] mem_addr;
  logic        busy, done, err;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [25:0] wlog [$];

  svi_ioctl_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_we         (mem_we),
    .mem_rdy        (mem_rdy),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .byte_count     (byte_count),
    .checksum       (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  // Record every accepted memory write and every cycle that done is high.
  always @(posedge clk_sys) begin
    if (mem_we && mem_rdy) wlog.push_back({mem_addr, mem_din});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      cyc();
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    cyc();
    ioctl_wr   = 1'b0;
  endtask

  task automatic check_log(input string tag, input int n, input logic [17:0] base,
                           input logic [7:0] d0, input logic [7:0] dstep);
    check({tag, "_nwr"}, 32'(wlog.size()), 32'(n));
    for (int i = 0; i < n && i < wlog.size(); i++)
      check({tag, "_wr"}, 32'(wlog[i]), 32'({base + 18'(i), d0 + 8'(i) * dstep}));
  endtask

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; ioctl_dout = 8'd0; mem_rdy = 1'b0;
    cyc(); cyc();
    check("rst_busy", 32'(busy), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_wait", 32'(ioctl_wait), 0);
    check("rst_flags", {29'd0, done, err, 1'b0}, 0);
    check("rst_cnt", 32'(byte_count), 0);
    check("rst_cks", 32'(checksum), 0);
    reset = 1'b0;
    cyc();

    // 1: four bytes into slot 1, memory always ready.
    wlog.delete(); done_cnt = 0;
    mem_rdy = 1'b1; ioctl_index = 8'd1; ioctl_download = 1'b1;
    cyc();
    check("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) strobe(25'(i), 8'h11 * 8'(i + 1));
    cyc();
    ioctl_download = 1'b0;
    wait_idle("t1_idle");
    check_log("t1", 4, 18'h10000, 8'h11, 8'h11);
    check("t1_cnt", 32'(byte_count), 4);
    check("t1_err", 32'(err), 0);
    check("t1_done", 32'(done_cnt), 1);
    check("t1_cks", 32'(checksum), CkEn ? 32'hAA : 32'h0);

    // 2: memory stalled, source obeys wait.
    wlog.delete();
    mem_rdy = 1'b0; ioctl_index = 8'd0; ioctl_download = 1'b1;
    cyc();
    begin
      int k = 0;
      for (int i = 0; i < 8; i++) begin
        if (ioctl_wait) break;
        strobe(25'(k), 8'hA0 + 8'(k));
        k++;
      end
      check("t2_sent", 32'(k), 3);
    end
    check("t2_wait", 32'(ioctl_wait), 1);
    check("t2_cnt", 32'(byte_count), 3);
    check("t2_err", 32'(err), 0);
    check("t2_nwr", 32'(wlog.size()), 0);
    check("t2_we", 32'(mem_we), 1);
    check("t2_head", {14'd0, mem_addr}, 0);
    check("t2_din", 32'(mem_din), 32'hA0);

    // 3: ignore wait; the fourth byte fills the FIFO and the fifth is dropped.
    strobe(25'd3, 8'hA3);
    check("t3_fill_cnt", 32'(byte_count), 4);
    check("t3_fill_err", 32'(err), 0);
    strobe(25'd4, 8'hA4);
    check("t3_drop_cnt", 32'(byte_count), 4);
    check("t3_drop_err", 32'(err), 1);
    mem_rdy = 1'b1; ioctl_download = 1'b0;
    wait_idle("t3_idle");
    check_log("t3", 4, 18'h00000, 8'hA0, 8'h01);
    check("t3_sticky", 32'(err), 1);
    check("t3_cks", 32'(checksum), CkEn ? 32'h86 : 32'h0);
    ioctl_download = 1'b1;
    cyc();
    check("t3_restart_err", 32'(err), 0);
    check("t3_restart_cnt", 32'(byte_count), 0);

    // 4: offset beyond the slot is rejected.
    wlog.delete();
    strobe(25'h10000, 8'h55);
    cyc(); cyc();
    check("t4_err", 32'(err), 1);
    check("t4_cnt", 32'(byte_count), 0);
    check("t4_nwr", 32'(wlog.size()), 0);
    ioctl_download = 1'b0;
    wait_idle("t4_idle");

    // 5: end the window with 3 bytes queued while mem_rdy toggles.
    wlog.delete(); done_cnt = 0;
    mem_rdy = 1'b0; ioctl_index = 8'd1; ioctl_download = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) strobe(25'(5 + i), 8'(i + 1));
    ioctl_download = 1'b0;
    begin
      int early = 0;
      for (int i = 0; i < 40; i++) begin
        mem_rdy = ~mem_rdy;
        cyc();
        if (!busy) break;
        if (wlog.size() < 3 && !busy) early++;
      end
      check("t5_busy_held", 32'(early), 0);
    end
    check("t5_idle", 32'(busy), 0);
    check_log("t5", 3, 18'h10005, 8'h01, 8'h01);
    check("t5_done", 32'(done_cnt), 1);

    // 6: reset with 2 bytes queued.
    wlog.delete();
    mem_rdy = 1'b0; ioctl_index = 8'd0; ioctl_download = 1'b1;
    cyc();
    strobe(25'd0, 8'h77);
    strobe(25'd1, 8'h78);
    check("t6_we_pre", 32'(mem_we), 1);
    #3 reset = 1'b1;
    #1;
    check("t6_we_async", 32'(mem_we), 0);
    check("t6_busy_async", 32'(busy), 0);
    mem_rdy = 1'b1; ioctl_download = 1'b0;
    cyc();
    reset = 1'b0;
    cyc(); cyc();
    check("t6_nwr", 32'(wlog.size()), 0);
    ioctl_download = 1'b1;
    cyc();
    check("t6_cnt", 32'(byte_count), 0);
    check("t6_busy", 32'(busy), 1);
    ioctl_download = 1'b0;
    wait_idle("t6_idle");
    check("t6_nwr_end", 32'(wlog.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
